fc_layer_engine: RTL and testbench

- Hardware realisation of one quantized fully-connected MNIST layer.
- Consumes streamed int8 activation/weight pairs and per-neuron int32 bias. Applies zero-point offsets and runs the 16x16 multiplier under test. Accumulates, adds bias, optionally applies ReLU, requantizes, and emits one int8 result per neuron.
- It is the hardware responder to the software layer flow that drives the multiplier operand-by-operand. Its outputs are bit-comparable with the golden layer result files.

---
 rtl/fc_layer_pkg.sv | 76 +++++++
 rtl/fc_layer_engine_mult.sv | 23 ++
 rtl/fc_layer_engine.sv | 141 ++++++++++++++
 tb/tb_fc_layer_engine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_layer_pkg.sv
// Shared types and requantization arithmetic for the fully-connected layer engine.
// Optional macro SAT_OUT_EN: saturate the 16-bit output to int8 instead of truncating.
package fc_layer_pkg;

  localparam int unsigned ACC_W  = 32;
  localparam int unsigned PROD_W = 64;
  localparam int unsigned OP_W   = 16;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_BIAS,
    S_QMUL,
    S_QSHIFT,
    S_OUT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic        [CNT_W-1:0] n_in;
    logic        [CNT_W-1:0] n_out;
    logic signed [7:0]       input_zp;
    logic signed [7:0]       filter_zp;
    logic signed [7:0]       output_zp;
    logic signed [31:0]      quant_mult;
    logic signed [31:0]      quant_shift;
    logic                    relu_en;
  } cfg_t;

  // p64 = r32 * mult + 2^(ts-1), ts = 31 - shift
  function automatic logic signed [PROD_W-1:0] qmul(
    input logic signed [ACC_W-1:0] r32,
    input logic signed [31:0]      mult,
    input logic signed [31:0]      shift
  );
    logic signed [31:0]       ts_m1;
    logic signed [PROD_W-1:0] a64;
    logic signed [PROD_W-1:0] b64;
    ts_m1 = 32'sd30 - shift;
    a64   = {{32{r32[31]}}, r32};
    b64   = {{32{mult[31]}}, mult};
    return (a64 * b64) + (64'sd1 <<< ts_m1[5:0]);
  endfunction

  // Arithmetic shift by ts, add output zero point, reduce to int8
  function automatic logic [7:0] qshift(
    input logic signed [PROD_W-1:0] p64,
    input logic signed [31:0]       shift,
    input logic signed [7:0]        out_zp
  );
    logic signed [31:0]       ts;
    logic signed [PROD_W-1:0] s64;
    logic signed [15:0]       o16;
    ts  = 32'sd31 - shift;
    s64 = p64 >>> ts[5:0];
    o16 = s64[15:0] + {{8{out_zp[7]}}, out_zp};
`ifdef SAT_OUT_EN
    if (o16 > 16'sd127)       return 8'h7F;
    else if (o16 < -16'sd128) return 8'h80;
    else                      return o16[7:0];
`else
    return o16[7:0];
`endif
  endfunction

  function automatic logic [7:0] requant(
    input logic signed [ACC_W-1:0] r32,
    input logic signed [31:0]      mult,
    input logic signed [31:0]      shift,
    input logic signed [7:0]       out_zp
  );
    return qshift(qmul(r32, mult, shift), shift, out_zp);
  endfunction

endpackage

// File: rtl/fc_layer_engine_mult.sv
// fc_mult_wrap: 16x16 signed multiplier selected at compile time.
// Macros MULT_BASE_LOG / MULT_DR_ALM_7TRUNC / MULT_IMPROVED_DR_ALM_7TRUNC pick an
// approximate core; with none defined the exact product is used.
module fc_mult_wrap
  import fc_layer_pkg::*;
(
  input  logic signed [OP_W-1:0]   i_a,
  input  logic signed [OP_W-1:0]   i_b,
  output logic signed [2*OP_W-1:0] o_z
);

`ifdef MULT_BASE_LOG
  base_log_mult u_mult (i_a, i_b, o_z);
`elsif MULT_DR_ALM_7TRUNC
  dr_alm_core_16bit7trunc u_mult (i_a, i_b, o_z);
`elsif MULT_IMPROVED_DR_ALM_7TRUNC
  improved_dr_alm_16_7trunc u_mult (i_a, i_b, o_z);
`else
  // Exact signed product, bit-equivalent to exact_16bit_mult
  always_comb o_z = i_a * i_b;
`endif

endmodule

// File: rtl/fc_layer_engine.sv
// fc_layer_engine: streamed int8 fully-connected layer, one int8 result per neuron.
// Optional macro SAT_OUT_EN (see fc_layer_pkg) saturates results instead of truncating.
module fc_layer_engine
  import fc_layer_pkg::*;
#(
  parameter int unsigned MAX_IN  = 1024,
  parameter int unsigned MAX_OUT = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic [$clog2(MAX_IN+1)-1:0]  i_cfg_n_in,
  input  logic [$clog2(MAX_OUT+1)-1:0] i_cfg_n_out,
  input  logic signed [7:0]            i_cfg_input_zp,
  input  logic signed [7:0]            i_cfg_filter_zp,
  input  logic signed [7:0]            i_cfg_output_zp,
  input  logic signed [31:0]           i_cfg_quant_mult,
  input  logic signed [31:0]           i_cfg_quant_shift,
  input  logic                         i_cfg_relu_en,
  input  logic                         i_op_valid,
  output logic                         o_op_ready,
  input  logic [7:0]                   i_act,
  input  logic [7:0]                   i_wgt,
  input  logic [31:0]                  i_bias,
  output logic                         o_res_valid,
  input  logic                         i_res_ready,
  output logic [7:0]                   o_res,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int unsigned BEAT_W = $clog2(MAX_IN + 1);
  localparam int unsigned NRN_W  = $clog2(MAX_OUT + 1);

  state_t                   r_state;
  state_t                   w_next;
  cfg_t                     r_cfg;
  logic [BEAT_W-1:0]        r_beat;
  logic [NRN_W-1:0]         r_neuron;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  r_bias;
  logic signed [PROD_W-1:0] r_p64;
  logic [7:0]               r_res;

  logic signed [OP_W-1:0]   w_a16;
  logic signed [OP_W-1:0]   w_b16;
  logic signed [2*OP_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_acc_b;
  logic                     w_last_beat;
  logic                     w_last_neuron;

  assign w_a16         = {{8{i_act[7]}}, i_act} - {{8{r_cfg.input_zp[7]}}, r_cfg.input_zp};
  assign w_b16         = {{8{i_wgt[7]}}, i_wgt} - {{8{r_cfg.filter_zp[7]}}, r_cfg.filter_zp};
  assign w_acc_b       = r_acc + r_bias;
  assign w_last_beat   = (r_beat == BEAT_W'(r_cfg.n_in - 16'd1));
  assign w_last_neuron = (r_neuron == NRN_W'(r_cfg.n_out - 16'd1));
  assign o_res         = r_res;

  fc_mult_wrap u_mult (
    .i_a (w_a16),
    .i_b (w_b16),
    .o_z (w_prod)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and handshake/status outputs
  always_comb begin
    w_next      = r_state;
    o_op_ready  = 1'b0;
    o_res_valid = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_MAC;
      S_MAC: begin
        o_op_ready = 1'b1;
        o_busy     = 1'b1;
        if (i_op_valid && w_last_beat) w_next = S_BIAS;
      end
      S_BIAS:   begin o_busy = 1'b1; w_next = S_QMUL;   end
      S_QMUL:   begin o_busy = 1'b1; w_next = S_QSHIFT; end
      S_QSHIFT: begin o_busy = 1'b1; w_next = S_OUT;    end
      S_OUT: begin
        o_busy      = 1'b1;
        o_res_valid = 1'b1;
        if (i_res_ready) w_next = w_last_neuron ? S_DONE : S_MAC;
      end
      S_DONE:   begin o_done = 1'b1; w_next = S_IDLE; end
      default:  w_next = S_IDLE;
    endcase
  end

  // Config latch, counters, accumulator and requantization pipeline
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cfg    <= '0;
      r_beat   <= '0;
      r_neuron <= '0;
      r_acc    <= '0;
      r_bias   <= '0;
      r_p64    <= '0;
      r_res    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_cfg.n_in        <= CNT_W'(i_cfg_n_in);
          r_cfg.n_out       <= CNT_W'(i_cfg_n_out);
          r_cfg.input_zp    <= i_cfg_input_zp;
          r_cfg.filter_zp   <= i_cfg_filter_zp;
          r_cfg.output_zp   <= i_cfg_output_zp;
          r_cfg.quant_mult  <= i_cfg_quant_mult;
          r_cfg.quant_shift <= i_cfg_quant_shift;
          r_cfg.relu_en     <= i_cfg_relu_en;
          r_acc             <= '0;
          r_beat            <= '0;
          r_neuron          <= '0;
        end
        S_MAC: if (i_op_valid) begin
          r_acc  <= r_acc + w_prod;
          r_beat <= r_beat + 1'b1;
          if (r_beat == '0) r_bias <= i_bias;
        end
        S_BIAS:   r_acc <= (r_cfg.relu_en && w_acc_b[ACC_W-1]) ? '0 : w_acc_b;
        S_QMUL:   r_p64 <= qmul(r_acc, r_cfg.quant_mult, r_cfg.quant_shift);
        S_QSHIFT: r_res <= qshift(r_p64, r_cfg.quant_shift, r_cfg.output_zp);
        S_OUT: if (i_res_ready && !w_last_neuron) begin
          r_neuron <= r_neuron + 1'b1;
          r_acc    <= '0;
          r_beat   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_engine.sv
// Self-checking bench for fc_layer_engine: vector table plus multi-cycle sequences.
module tb_fc_layer_engine;

  logic               i_clk = 1'b0;
  logic               i_rst_n = 1'b0;
  logic               i_start = 1'b0;
  logic [10:0]        i_cfg_n_in = '0;
  logic [10:0]        i_cfg_n_out = '0;
  logic signed [7:0]  i_cfg_input_zp = '0;
  logic signed [7:0]  i_cfg_filter_zp = '0;
  logic signed [7:0]  i_cfg_output_zp = '0;
  logic signed [31:0] i_cfg_quant_mult = '0;
  logic signed [31:0] i_cfg_quant_shift = '0;
  logic               i_cfg_relu_en = 1'b0;
  logic               i_op_valid = 1'b0;
  logic               i_res_ready = 1'b0;
  logic [7:0]         i_act = '0;
  logic [7:0]         i_wgt = '0;
  logic [31:0]        i_bias = '0;
  logic               o_op_ready, o_res_valid, o_busy, o_done;
  logic [7:0]         o_res;

  fc_layer_engine #(.MAX_IN(1024), .MAX_OUT(1024)) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_start           (i_start),
    .i_cfg_n_in        (i_cfg_n_in),
    .i_cfg_n_out       (i_cfg_n_out),
    .i_cfg_input_zp    (i_cfg_input_zp),
    .i_cfg_filter_zp   (i_cfg_filter_zp),
    .i_cfg_output_zp   (i_cfg_output_zp),
    .i_cfg_quant_mult  (i_cfg_quant_mult),
    .i_cfg_quant_shift (i_cfg_quant_shift),
    .i_cfg_relu_en     (i_cfg_relu_en),
    .i_op_valid        (i_op_valid),
    .o_op_ready        (o_op_ready),
    .i_act             (i_act),
    .i_wgt             (i_wgt),
    .i_bias            (i_bias),
    .o_res_valid       (o_res_valid),
    .i_res_ready       (i_res_ready),
    .o_res             (o_res),
    .o_busy            (o_busy),
    .o_done            (o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int               n_in;
    logic [3:0][7:0]  act;
    logic [3:0][7:0]  wgt;
    logic signed [7:0] izp, fzp, ozp;
    logic [31:0]      bias, mult, shift;
    logic             relu;
    logic [7:0]       exp;
  } vec_t;

  vec_t       tbl[9];
  logic [7:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_done = 0;
  int         cyc = 0;
  int         hs_cyc = -10;

`ifdef SAT_OUT_EN
  localparam logic [7:0] E_RELU_OFF = 8'h80;
  localparam logic [7:0] E_OVF      = 8'h7F;
`else
  localparam logic [7:0] E_RELU_OFF = 8'h67;
  localparam logic [7:0] E_OVF      = 8'hF4;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic vec_t mk(input int n,
                              input logic [7:0] a0, a1, a2, a3, w0, w1, w2, w3,
                              input logic [7:0] izp, fzp, ozp,
                              input logic [31:0] bias, mult, shift,
                              input logic relu, input logic [7:0] expv);
    vec_t v;
    v.n_in = n;
    v.act[0] = a0; v.act[1] = a1; v.act[2] = a2; v.act[3] = a3;
    v.wgt[0] = w0; v.wgt[1] = w1; v.wgt[2] = w2; v.wgt[3] = w3;
    v.izp = izp; v.fzp = fzp; v.ozp = ozp;
    v.bias = bias; v.mult = mult; v.shift = shift;
    v.relu = relu; v.exp = expv;
    return v;
  endfunction

  always @(posedge i_clk) cyc <= cyc + 1;

  // Result scoreboard and done-pulse monitor, sampled 1 after the falling edge
  always @(negedge i_clk) begin
    #1;
    if (i_rst_n && o_res_valid && i_res_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL res_unexpected: got %0h expected none", o_res);
      end else begin
        check("res", {56'd0, o_res}, {56'd0, exp_q.pop_front()});
      end
      hs_cyc = cyc;
    end
    if (i_rst_n && o_done) begin
      n_done++;
      check("done_after_hs", cyc, hs_cyc + 1);
      check("busy_in_done", {63'd0, o_busy}, 64'd0);
    end
  end

  task automatic start_job(input vec_t v, input int n_out);
    i_cfg_n_in        = 11'(v.n_in);
    i_cfg_n_out       = 11'(n_out);
    i_cfg_input_zp    = v.izp;
    i_cfg_filter_zp   = v.fzp;
    i_cfg_output_zp   = v.ozp;
    i_cfg_quant_mult  = v.mult;
    i_cfg_quant_shift = v.shift;
    i_cfg_relu_en     = v.relu;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    check("busy_after_start", {63'd0, o_busy}, 64'd1);
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer
  task automatic send_beat(input logic [7:0] a, input logic [7:0] w, input logic [31:0] b);
    int t = 0;
    i_act = a; i_wgt = w; i_bias = b; i_op_valid = 1'b1;
    while (!o_op_ready && t < 100) begin
      @(negedge i_clk);
      t++;
    end
    if (!o_op_ready) check("beat_timeout", {63'd0, o_op_ready}, 64'd1);
    @(negedge i_clk);
    i_op_valid = 1'b0;
  endtask

  task automatic run_neuron(input vec_t v);
    for (int i = 0; i < v.n_in; i++)
      send_beat(v.act[i], v.wgt[i], (i == 0) ? v.bias : 32'hDEADBEEF);
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (n_done == d0 && t < 60) begin
      @(negedge i_clk);
      t++;
    end
    check("done_count", n_done, d0 + 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   d0;
    int   lat;
    int   t;
    vec_t m;

    tbl[0] = mk(2, 8'd10, 8'd20, 0, 0, 8'd3, 8'hFC, 0, 0, 8'd0, 8'd0, 8'h80,
                32'd100, 32'h40000000, 32'd0, 1'b1, 8'h99);
    tbl[1] = mk(1, 8'd10, 0, 0, 0, 8'hFB, 0, 0, 0, 8'd0, 8'd0, 8'h80,
                32'd0, 32'h40000000, 32'd0, 1'b1, 8'h80);
    tbl[2] = mk(1, 8'd10, 0, 0, 0, 8'hFB, 0, 0, 0, 8'd0, 8'd0, 8'h80,
                32'd0, 32'h40000000, 32'd0, 1'b0, E_RELU_OFF);
    tbl[3] = mk(1, 8'd5, 0, 0, 0, 8'd2, 0, 0, 0, 8'h80, 8'd0, 8'd0,
                32'd0, 32'h40000000, 32'hFFFFFFFE, 1'b0, 8'h21);
    tbl[4] = mk(1, 8'd100, 0, 0, 0, 8'd10, 0, 0, 0, 8'd0, 8'd0, 8'd0,
                32'd0, 32'h40000000, 32'd0, 1'b0, E_OVF);
    tbl[5] = mk(1, 8'd3, 0, 0, 0, 8'd7, 0, 0, 0, 8'd1, 8'd2, 8'd10,
                32'hFFFFFFFC, 32'h40000000, 32'd1, 1'b0, 8'h10);
    tbl[6] = mk(1, 8'd10, 0, 0, 0, 8'd10, 0, 0, 0, 8'd0, 8'd0, 8'd3,
                32'h7FFFFFFF, 32'h40000000, 32'd0, 1'b1, 8'h03);
    tbl[7] = mk(4, 8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0,
                32'd0, 32'h7FFFFFFF, 32'd0, 1'b0, 8'h0A);
    tbl[8] = mk(1, 8'd7, 0, 0, 0, 8'd3, 0, 0, 0, 8'd0, 8'd0, 8'd0,
                32'd0, 32'hC0000000, 32'd0, 1'b0, 8'hF6);

    // Reset state
    #12;
    check("reset_outs", {55'd0, o_op_ready, o_res_valid, o_busy, o_done, o_res}, 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_res_ready = 1'b1;
    @(negedge i_clk);

    // Table-driven single-neuron jobs with latency check
    for (int k = 0; k < 9; k++) begin
      d0 = n_done;
      start_job(tbl[k], 1);
      exp_q.push_back(tbl[k].exp);
      run_neuron(tbl[k]);
      lat = 1;
      while (!o_res_valid && lat < 20) begin
        @(negedge i_clk);
        lat++;
      end
      check("latency", lat, 4);
      wait_done(d0);
      @(negedge i_clk);
    end

    // Three neurons, backpressure on the second result
    m = mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0, 8'd0, 8'd0,
           32'd0, 32'h40000000, 32'd0, 1'b0, 8'h00);
    d0 = n_done;
    start_job(m, 3);
    exp_q.push_back(8'h0C);
    exp_q.push_back(8'hEC);
    exp_q.push_back(8'h06);
    send_beat(8'd2, 8'd4, 32'd1);
    send_beat(8'd3, 8'd5, 32'hDEADBEEF);
    send_beat(8'hFA, 8'd7, 32'd0);
    i_res_ready = 1'b0;
    send_beat(8'd2, 8'd1, 32'hDEADBEEF);
    t = 0;
    while (!o_res_valid && t < 20) begin
      @(negedge i_clk);
      t++;
    end
    for (int s = 0; s < 6; s++) begin
      check("stall_res", {56'd0, o_res}, 64'hEC);
      check("stall_valid", {63'd0, o_res_valid}, 64'd1);
      check("stall_ready", {63'd0, o_op_ready}, 64'd0);
      @(negedge i_clk);
    end
    i_res_ready = 1'b1;
    send_beat(8'd1, 8'd1, 32'd9);
    send_beat(8'd1, 8'd1, 32'hDEADBEEF);
    wait_done(d0);
    @(negedge i_clk);

    // Reset in the middle of accumulation, then a clean rerun
    start_job(tbl[7], 1);
    exp_q.push_back(tbl[7].exp);
    send_beat(tbl[7].act[0], tbl[7].wgt[0], tbl[7].bias);
    send_beat(tbl[7].act[1], tbl[7].wgt[1], 32'hDEADBEEF);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("async_reset_outs", {55'd0, o_op_ready, o_res_valid, o_busy, o_done, o_res}, 64'd0);
    exp_q.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    d0 = n_done;
    start_job(tbl[7], 1);
    exp_q.push_back(tbl[7].exp);
    run_neuron(tbl[7]);
    wait_done(d0);
    @(negedge i_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
